// File: rtl/tcs_color_sampler.sv
// Purpose : drives the S2/S3 filter selects of a light-to-frequency color sensor,
//           counts sensor edges over a gate window for red, green and blue,
//           scales and saturates each count to 8 bits, and publishes all three at once.
// Latency : one frame = 3*(SETTLE_CYCLES+GATE_CYCLES)+1 cycles; bytes and valid
//           appear the cycle after PUBLISH.
// Backpressure: none; valid is a one-cycle strobe and the bytes hold until the next publish.
//
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   sensor_out      : asynchronous sensor frequency output (synchronized internally)
//   en              : run enable; frames repeat back-to-back while high
//   s2, s3          : filter select (red=00, green=11, blue=01, idle=00)
//   red/green/blue  : last published channel bytes
//   valid           : one-cycle strobe when red/green/blue update
//   busy            : high whenever the sequencer is not idle
module tcs_color_sampler #(
    parameter int GATE_CYCLES   = 50000,
    parameter int SETTLE_CYCLES = 1000,
    parameter int CNT_W         = 16,   // must be >= 8
    parameter int SHIFT         = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sensor_out,
    input  logic       en,
    output logic       s2,
    output logic       s3,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic       valid,
    output logic       busy
);

    localparam int TMAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0]    SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0]    GATE_LAST   = TW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] BYTE_MAX    = CNT_W'(255);

    typedef enum logic [2:0] {
        IDLE, SETTLE_R, COUNT_R, SETTLE_G, COUNT_G, SETTLE_B, COUNT_B, PUBLISH
    } state_e;

    state_e           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       sync_q;
    logic [7:0]       hold_r_q, hold_r_d, hold_g_q, hold_g_d, hold_b_q, hold_b_d;
    logic [7:0]       red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic             valid_q, valid_d;

    logic             edge_det;
    logic             settle_done, gate_done;

    // sync_q[1:0] is the two-flop synchronizer, sync_q[2] the previous synced value.
    assign edge_det    = sync_q[1] & ~sync_q[2];
    assign settle_done = (timer_q == SETTLE_LAST);
    assign gate_done   = (timer_q == GATE_LAST);

    // ---------------- state register and datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            cnt_q    <= '0;
            sync_q   <= '0;
            hold_r_q <= '0;
            hold_g_q <= '0;
            hold_b_q <= '0;
            red_q    <= '0;
            green_q  <= '0;
            blue_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            cnt_q    <= cnt_d;
            sync_q   <= {sync_q[1:0], sensor_out};
            hold_r_q <= hold_r_d;
            hold_g_q <= hold_g_d;
            hold_b_q <= hold_b_d;
            red_q    <= red_d;
            green_q  <= green_d;
            blue_q   <= blue_d;
            valid_q  <= valid_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (en)          state_d = SETTLE_R;
            SETTLE_R: if (settle_done) state_d = COUNT_R;
            COUNT_R:  if (gate_done)   state_d = SETTLE_G;
            SETTLE_G: if (settle_done) state_d = COUNT_G;
            COUNT_G:  if (gate_done)   state_d = SETTLE_B;
            SETTLE_B: if (settle_done) state_d = COUNT_B;
            COUNT_B:  if (gate_done)   state_d = PUBLISH;
            PUBLISH:  state_d = en ? SETTLE_R : IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // ---------------- datapath next values ----------------
    logic             counting, leaving;
    logic [CNT_W-1:0] cnt_inc, scaled;
    logic [7:0]       cnt_byte;

    always_comb begin
        counting = (state_q == COUNT_R) || (state_q == COUNT_G) || (state_q == COUNT_B);
        leaving  = (state_d != state_q);

        // Counter saturates rather than wraps; includes an edge seen in the
        // current cycle so the last gate cycle is counted at capture.
        cnt_inc = cnt_q;
        if (counting && edge_det && (cnt_q != CNT_MAX)) begin
            cnt_inc = cnt_q + CNT_W'(1);
        end
        scaled   = cnt_inc >> SHIFT;
        cnt_byte = (scaled > BYTE_MAX) ? 8'hFF : scaled[7:0];

        timer_d  = (leaving || (state_q == IDLE)) ? '0 : timer_q + TW'(1);

        cnt_d    = cnt_inc;
        if (leaving && !counting) begin
            cnt_d = '0;           // cleared on entry to each gate window
        end

        hold_r_d = hold_r_q;
        hold_g_d = hold_g_q;
        hold_b_d = hold_b_q;
        if (leaving && (state_q == COUNT_R)) hold_r_d = cnt_byte;
        if (leaving && (state_q == COUNT_G)) hold_g_d = cnt_byte;
        if (leaving && (state_q == COUNT_B)) hold_b_d = cnt_byte;

        red_d   = red_q;
        green_d = green_q;
        blue_d  = blue_q;
        valid_d = 1'b0;
        if (state_q == PUBLISH) begin
            red_d   = hold_r_q;
            green_d = hold_g_q;
            blue_d  = hold_b_q;
            valid_d = 1'b1;
        end
    end

    // ---------------- output logic ----------------
    always_comb begin
        s2   = 1'b0;
        s3   = 1'b0;
        busy = (state_q != IDLE);
        case (state_q)
            SETTLE_G, COUNT_G: begin
                s2 = 1'b1;
                s3 = 1'b1;
            end
            SETTLE_B, COUNT_B: begin
                s3 = 1'b1;
            end
            default: ;
        endcase
    end

    assign red   = red_q;
    assign green = green_q;
    assign blue  = blue_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_tcs_color_sampler.sv
// Purpose : randomized scoreboard bench for tcs_color_sampler with a frame-level reference model.
// Latency : expected bytes are pushed in the PUBLISH cycle and popped when valid appears.
// Backpressure: none; the monitor checks every valid strobe against the queue.
module tb_tcs_color_sampler;

    localparam int S     = 10;
    localparam int G     = 100;
    localparam int SEG   = S + G;
    localparam int FRAME = 3 * SEG + 1;

    logic       clk = 1'b0;
    logic       rst, en, sensor_out;
    logic       s2, s3, valid, busy;
    logic [7:0] red, green, blue;

    logic       en_sat, sat_sensor;
    logic       sa_s2, sa_s3, sa_valid, sa_busy, sb_s2, sb_s3, sb_valid, sb_busy;
    logic [7:0] sa_r, sa_g, sa_b, sb_r, sb_g, sb_b;

    always #5 clk = ~clk;

    tcs_color_sampler #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(16), .SHIFT(0)) dut (
        .clk(clk), .rst(rst), .sensor_out(sensor_out), .en(en),
        .s2(s2), .s3(s3), .red(red), .green(green), .blue(blue),
        .valid(valid), .busy(busy));

    tcs_color_sampler #(.GATE_CYCLES(1000), .SETTLE_CYCLES(S), .CNT_W(16), .SHIFT(0)) u_sat0 (
        .clk(clk), .rst(rst), .sensor_out(sat_sensor), .en(en_sat),
        .s2(sa_s2), .s3(sa_s3), .red(sa_r), .green(sa_g), .blue(sa_b),
        .valid(sa_valid), .busy(sa_busy));

    tcs_color_sampler #(.GATE_CYCLES(1000), .SETTLE_CYCLES(S), .CNT_W(16), .SHIFT(1)) u_sat1 (
        .clk(clk), .rst(rst), .sensor_out(sat_sensor), .en(en_sat),
        .s2(sb_s2), .s3(sb_s3), .red(sb_r), .green(sb_g), .blue(sb_b),
        .valid(sb_valid), .busy(sb_busy));

    typedef struct {
        int at;
        int r;
        int g;
        int b;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_r = 0, last_g = 0, last_b = 0;
    int   sat0_seen = 0, sat1_seen = 0;
    bit   fx [FRAME];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Sensor level for each cycle of one frame, indexed from SETTLE_R entry.
    task automatic build_frame(input int mode);
        int p [3];
        p[0] = 4; p[1] = 5; p[2] = 10;
        if (mode == 1) begin
            for (int c = 0; c < 3; c++) p[c] = $urandom_range(2, 12);
        end
        for (int i = 0; i < FRAME; i++) fx[i] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < SEG; k++) begin
                case (mode)
                    0, 1: fx[c*SEG+k] = ((k % p[c]) < (p[c] / 2));
                    2:    fx[c*SEG+k] = 1'($urandom_range(0, 1));
                    3:    fx[c*SEG+k] = (k < S - 4) ? 1'(k % 2) : 1'b0;
                    default: ;
                endcase
            end
        end
        if (mode == 4) begin
            fx[S-2]       = 1'b1;  // detected on first gate cycle of red
            fx[SEG-3]     = 1'b1;  // detected on last gate cycle of red
            fx[2*SEG-2]   = 1'b1;  // detected on first settle cycle of blue: dropped
            fx[3*SEG-3]   = 1'b1;  // detected on last gate cycle of blue
        end
    endtask

    // An edge reaches the detector two cycles after it appears on the pin;
    // count edges detected inside the channel's gate window.
    function automatic int model_byte(input int c, input int shift);
        int cnt;
        cnt = 0;
        for (int m = c*SEG + S; m < c*SEG + SEG; m++) begin
            if (fx[m-2] && !fx[m-3]) cnt++;
        end
        if (cnt > 65535) cnt = 65535;
        cnt = cnt >> shift;
        return (cnt > 255) ? 255 : cnt;
    endfunction

    // Caller guarantees the current cycle is the first SETTLE_R cycle.
    task automatic run_frame(input int mode, input int drop_at, input int rst_at);
        exp_t e;
        build_frame(mode);
        for (int i = 0; i < FRAME; i++) begin
            sensor_out = fx[i];
            if (i == drop_at) en = 1'b0;
            if (i == rst_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                en = 1'b0;
                sensor_out = 1'b0;
                check("rst_red", red, 0);
                check("rst_green", green, 0);
                check("rst_blue", blue, 0);
                check("rst_valid", valid, 0);
                check("rst_busy", busy, 0);
                check("rst_filter", {s2, s3}, 0);
                last_r = 0; last_g = 0; last_b = 0;
                return;
            end
            if (i == 0 || i == SEG - 1)       check("filter_red", {s2, s3}, 2'b00);
            if (i == SEG || i == 2*SEG - 1)   check("filter_green", {s2, s3}, 2'b11);
            if (i == 2*SEG || i == 3*SEG - 1) check("filter_blue", {s2, s3}, 2'b01);
            if (i == 3*SEG)                   check("filter_publish", {s2, s3}, 2'b00);
            if (i == 0 || i == 3*SEG)         check("busy_frame", busy, 1);
            if (i == FRAME - 1) begin
                e.at = cyc + 1;
                e.r  = model_byte(0, 0);
                e.g  = model_byte(1, 0);
                e.b  = model_byte(2, 0);
                if (mode == 0) begin
                    check("basic_red", e.r, 25);
                    check("basic_green", e.g, 20);
                    check("basic_blue", e.b, 10);
                end
                sb_q.push_back(e);
                last_r = e.r; last_g = e.g; last_b = e.b;
            end
            tick();
        end
    endtask

    // Monitor: compares every strobe against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid === 1'b1) begin
                check("valid_expected", (sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("valid_cycle", cyc, e.at);
                    check("pub_red", red, e.r);
                    check("pub_green", green, e.g);
                    check("pub_blue", blue, e.b);
                end
            end
            if (sa_valid === 1'b1) begin
                sat0_seen++;
                check("sat0_red", sa_r, 255);
                check("sat0_green", sa_g, 255);
                check("sat0_blue", sa_b, 255);
            end
            if (sb_valid === 1'b1) begin
                sat1_seen++;
                check("sat1_red", sb_r, 250);
                check("sat1_green", sb_g, 250);
                check("sat1_blue", sb_b, 250);
            end
        end
    end

    // Continuous period-2 input for the saturation instances.
    initial begin
        sat_sensor = 1'b0;
        en_sat     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        en_sat = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            sat_sensor = ~sat_sensor;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int seq [8];
        seq = '{1, 2, 3, 4, 1, 2, 1, 1};
        rst = 1'b1;
        en = 1'b0;
        sensor_out = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_red", red, 0);
        check("reset_green", green, 0);
        check("reset_blue", blue, 0);
        check("reset_valid", valid, 0);
        check("reset_busy", busy, 0);
        check("reset_filter", {s2, s3}, 0);
        repeat (3) tick();
        check("idle_no_en_busy", busy, 0);

        en = 1'b1;
        tick();
        run_frame(0, -1, -1);
        for (int k = 0; k < 8; k++) run_frame(seq[k], -1, -1);
        run_frame(1, 150, -1);            // en dropped during COUNT_G
        check("drop_busy", busy, 0);
        repeat (3) tick();
        check("drop_idle_busy", busy, 0);
        check("drop_idle_filter", {s2, s3}, 0);
        check("hold_red", red, last_r);
        check("hold_green", green, last_g);
        check("hold_blue", blue, last_b);

        en = 1'b1;
        tick();
        run_frame(2, -1, -1);
        run_frame(1, -1, 300);            // reset during COUNT_B
        repeat (400) tick();
        check("post_rst_busy", busy, 0);
        check("post_rst_red", red, 0);

        en = 1'b1;
        tick();
        run_frame(1, FRAME - 1, -1);      // en low in PUBLISH: stop after this frame
        repeat (5) tick();
        check("final_busy", busy, 0);
        check("sb_empty", sb_q.size(), 0);
        check("sat0_pulses", (sat0_seen > 0), 1);
        check("sat1_pulses", (sat1_seen > 0), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
